// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD digit display path: widths, FSM states, code legality.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package bcd_pkg;

  // Width of one BCD digit and number of decimal lines it drives.
  localparam int BCD_W      = 4;
  localparam int NUM_DIGITS = 10;

  // Display FSM: IDLE shows nothing, SHOW holds a digit on the one-hot lines.
  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  // Codes 10..15 have no decimal line and are treated as illegal input.
  function automatic logic is_legal_bcd(input logic [BCD_W-1:0] code);
    return code <= BCD_W'(NUM_DIGITS - 1);
  endfunction

endpackage

// File: rtl/bcd_to_onehot.sv
// Combinational BCD digit to 10-line one-hot conversion; illegal codes give all zeros.
// Latency: 0 cycles (pure combinational).
// Backpressure: none, no handshake.
module bcd_to_onehot
  import bcd_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [9:0] onehot
);

  logic legal;

  // Legality is checked once so an out-of-range code can never light a line.
  always_comb begin
    legal = is_legal_bcd(bcd);
  end

  // Compare against every line index rather than shifting, so codes 10..15
  // cannot alias onto a line.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      onehot[i] = legal && (bcd == BCD_W'(i));
    end
  end

endmodule

// File: rtl/bcd_onehot_hold_decoder.sv
// Registered BCD-to-one-hot decoder holding each accepted digit for HOLD_CYCLES cycles.
// Latency: 1 cycle from handshake to p0; consecutive digits are shown with no gap.
// Backpressure: one pending slot; in_ready = !pend_vld, illegal codes are consumed and flagged on err.
module bcd_onehot_hold_decoder
  import bcd_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic [3:0] bcd_in,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [9:0] p0,
  output logic       CHK,
  output logic       err
);

  // Counter counts down from HOLD_CYCLES-1; zero marks the last display cycle.
  localparam int             CNT_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] hold_cnt;
  logic [3:0]       pend_dat;
  logic             pend_vld;

  logic             in_fire;
  logic             in_legal;
  logic             take_digit;
  logic             bad_digit;
  logic             expiry;
  logic [9:0]       in_onehot;
  logic [9:0]       pend_onehot;

  // Upstream may hand over a digit whenever the pending slot is free.
  assign in_ready = !pend_vld;

  // Handshake qualification, split by code legality.
  always_comb begin
    in_fire    = in_valid && in_ready;
    in_legal   = is_legal_bcd(bcd_in);
    take_digit = in_fire && in_legal;
    bad_digit  = in_fire && !in_legal;
    expiry     = (state == SHOW) && (hold_cnt == '0);
  end

  // Decoder for a digit arriving on the input (idle load and expiry bypass).
  bcd_to_onehot u_in_dec (
    .bcd    (bcd_in),
    .onehot (in_onehot)
  );

  // Decoder for the buffered digit drained at expiry.
  bcd_to_onehot u_pend_dec (
    .bcd    (pend_dat),
    .onehot (pend_onehot)
  );

  // Illegal-code pulse; raised even when clr discards the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else begin
      err <= bad_digit;
    end
  end

  // Display FSM with registered one-hot, CHK, hold counter and pending slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      hold_cnt <= '0;
      pend_dat <= '0;
      pend_vld <= 1'b0;
      p0       <= '0;
      CHK      <= 1'b0;
    end else if (clr) begin
      // Clear beats every load; any digit offered this cycle is dropped.
      state    <= IDLE;
      hold_cnt <= '0;
      pend_vld <= 1'b0;
      p0       <= '0;
      CHK      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take_digit) begin
            p0       <= in_onehot;
            CHK      <= 1'b1;
            hold_cnt <= CNT_LOAD;
            state    <= SHOW;
          end
        end

        SHOW: begin
          if (!expiry) begin
            hold_cnt <= hold_cnt - CNT_W'(1);
            // Park the next digit; in_ready falls on the following cycle.
            if (take_digit) begin
              pend_dat <= bcd_in;
              pend_vld <= 1'b1;
            end
          end else if (pend_vld) begin
            // Drain the buffered digit; input cannot fire here since in_ready is low.
            p0       <= pend_onehot;
            hold_cnt <= CNT_LOAD;
            pend_vld <= 1'b0;
          end else if (take_digit) begin
            // Slot empty at expiry: bypass straight to the display, never via pend.
            p0       <= in_onehot;
            hold_cnt <= CNT_LOAD;
          end else begin
            p0    <= '0;
            CHK   <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
          p0    <= '0;
          CHK   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_onehot_hold_decoder.sv
// Self-checking bench for bcd_onehot_hold_decoder at HOLD_CYCLES=4 and HOLD_CYCLES=1.
// Latency: expected per-cycle display words are queued with the stimulus and popped after each edge.
// Backpressure: the bench only offers digits, acceptance is judged from in_ready before each edge.
module tb_bcd_onehot_hold_decoder;

  typedef struct packed {
    logic [9:0] p0;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       clr;
  logic [3:0] bcd_in;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] p0;
  logic       chk;
  logic       err;

  logic       clr1;
  logic [3:0] bcd1;
  logic       vld1;
  logic       rdy1;
  logic [9:0] p01;
  logic       chk1;
  logic       err1;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  exp_t exp1_q[$];

  always #5 clk = ~clk;

  bcd_onehot_hold_decoder #(.HOLD_CYCLES(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .bcd_in   (bcd_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .p0       (p0),
    .CHK      (chk),
    .err      (err)
  );

  bcd_onehot_hold_decoder #(.HOLD_CYCLES(1)) dut_h1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr1),
    .bcd_in   (bcd1),
    .in_valid (vld1),
    .in_ready (rdy1),
    .p0       (p01),
    .CHK      (chk1),
    .err      (err1)
  );

  function automatic logic [9:0] oh(input int d);
    logic [9:0] one;
    one = 10'd1;
    return one << d;
  endfunction

  function automatic exp_t mk(input logic [9:0] w, input logic e);
    exp_t x;
    x.p0  = w;
    x.err = e;
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; bcd_in = 4'd0;
    clr1 = 1'b0; vld1 = 1'b0; bcd1 = 4'd0;
    repeat (3) tick();
    n_checks++;
    if (p0 !== 10'd0 || chk !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: p0=%b chk=%b err=%b, expected all zero", p0, chk, err);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || rdy1 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: in_ready=%b rdy1=%b, expected 1 1", in_ready, rdy1);
    end
  endtask

  task automatic test_single_digit();
    exp_t e;
    bcd_in = 4'd7; in_valid = 1'b1;
    repeat (4) exp_q.push_back(mk(10'b0010000000, 1'b0));
    repeat (2) exp_q.push_back(mk(10'd0, 1'b0));
    for (int i = 0; i < 6; i++) begin
      tick();
      in_valid = 1'b0;
      e = exp_q.pop_front();
      n_checks++;
      if (p0 !== e.p0 || chk !== (|e.p0) || err !== e.err) begin
        n_fail++;
        $display("FAIL single_digit c%0d: p0=%b chk=%b err=%b, expected p0=%b chk=%b err=%b",
                 i, p0, chk, err, e.p0, |e.p0, e.err);
      end
    end
  endtask

  task automatic test_sweep();
    exp_t e;
    int   d;
    logic acc;
    logic seen_low;
    d = 0; seen_low = 1'b0;
    for (int k = 0; k < 10; k++) repeat (4) exp_q.push_back(mk(oh(k), 1'b0));
    repeat (2) exp_q.push_back(mk(10'd0, 1'b0));
    bcd_in = 4'd0; in_valid = 1'b1;
    for (int i = 0; i < 42; i++) begin
      acc = in_valid && in_ready;
      tick();
      if (acc) begin
        d++;
        if (d == 10) in_valid = 1'b0;
        else bcd_in = 4'(d);
      end
      if (!in_ready) seen_low = 1'b1;
      e = exp_q.pop_front();
      n_checks++;
      if (p0 !== e.p0 || chk !== (|e.p0) || err !== e.err) begin
        n_fail++;
        $display("FAIL sweep c%0d: p0=%b chk=%b err=%b, expected p0=%b chk=%b err=%b",
                 i, p0, chk, err, e.p0, |e.p0, e.err);
      end
    end
    n_checks++;
    if (d != 10 || seen_low !== 1'b1) begin
      n_fail++;
      $display("FAIL sweep_handshake: accepted=%0d ready_dropped=%b, expected 10 1", d, seen_low);
    end
  endtask

  task automatic test_illegal();
    exp_t e;
    bcd_in = 4'hC; in_valid = 1'b1;
    exp_q.push_back(mk(10'd0, 1'b1));
    exp_q.push_back(mk(10'd0, 1'b0));
    for (int i = 0; i < 2; i++) begin
      tick();
      in_valid = 1'b0;
      e = exp_q.pop_front();
      n_checks++;
      if (p0 !== e.p0 || chk !== (|e.p0) || err !== e.err) begin
        n_fail++;
        $display("FAIL illegal_idle c%0d: p0=%b chk=%b err=%b, expected p0=%b chk=%b err=%b",
                 i, p0, chk, err, e.p0, |e.p0, e.err);
      end
    end
    bcd_in = 4'd3; in_valid = 1'b1;
    exp_q.push_back(mk(oh(3), 1'b0));
    exp_q.push_back(mk(oh(3), 1'b1));
    exp_q.push_back(mk(oh(3), 1'b0));
    exp_q.push_back(mk(oh(3), 1'b0));
    exp_q.push_back(mk(10'd0, 1'b0));
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) bcd_in = 4'hF;
      else in_valid = 1'b0;
      if (i == 1) begin
        n_checks++;
        if (in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL illegal_pend_empty: in_ready=%b, expected 1", in_ready);
        end
      end
      e = exp_q.pop_front();
      n_checks++;
      if (p0 !== e.p0 || chk !== (|e.p0) || err !== e.err) begin
        n_fail++;
        $display("FAIL illegal_show c%0d: p0=%b chk=%b err=%b, expected p0=%b chk=%b err=%b",
                 i, p0, chk, err, e.p0, |e.p0, e.err);
      end
    end
  endtask

  task automatic test_bypass();
    exp_t e;
    bcd_in = 4'd2; in_valid = 1'b1;
    repeat (4) exp_q.push_back(mk(oh(2), 1'b0));
    repeat (4) exp_q.push_back(mk(oh(5), 1'b0));
    exp_q.push_back(mk(10'd0, 1'b0));
    for (int i = 0; i < 9; i++) begin
      tick();
      if (i == 3) begin
        bcd_in = 4'd5; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      e = exp_q.pop_front();
      n_checks++;
      if (p0 !== e.p0 || chk !== (|e.p0) || err !== e.err) begin
        n_fail++;
        $display("FAIL bypass c%0d: p0=%b chk=%b err=%b, expected p0=%b chk=%b err=%b",
                 i, p0, chk, err, e.p0, |e.p0, e.err);
      end
    end
  endtask

  task automatic test_clear();
    exp_t e;
    bcd_in = 4'd4; in_valid = 1'b1;
    repeat (2) exp_q.push_back(mk(oh(4), 1'b0));
    repeat (5) exp_q.push_back(mk(10'd0, 1'b0));
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i == 0) bcd_in = 4'd8;
      if (i == 1) begin
        in_valid = 1'b0;
        n_checks++;
        if (in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL clear_pend_full: in_ready=%b, expected 0", in_ready);
        end
        clr = 1'b1;
      end
      if (i == 2) begin
        clr = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL clear_ready: in_ready=%b, expected 1", in_ready);
        end
      end
      e = exp_q.pop_front();
      n_checks++;
      if (p0 !== e.p0 || chk !== (|e.p0) || err !== e.err) begin
        n_fail++;
        $display("FAIL clear c%0d: p0=%b chk=%b err=%b, expected p0=%b chk=%b err=%b",
                 i, p0, chk, err, e.p0, |e.p0, e.err);
      end
    end
  endtask

  task automatic test_clr_same_cycle();
    exp_t e;
    clr = 1'b1; bcd_in = 4'd6; in_valid = 1'b1;
    exp_q.push_back(mk(10'd0, 1'b0));
    exp_q.push_back(mk(10'd0, 1'b1));
    exp_q.push_back(mk(10'd0, 1'b0));
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 0) bcd_in = 4'hB;
      else begin
        clr = 1'b0; in_valid = 1'b0;
      end
      e = exp_q.pop_front();
      n_checks++;
      if (p0 !== e.p0 || chk !== (|e.p0) || err !== e.err) begin
        n_fail++;
        $display("FAIL clr_same_cycle c%0d: p0=%b chk=%b err=%b, expected p0=%b chk=%b err=%b",
                 i, p0, chk, err, e.p0, |e.p0, e.err);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bcd_in = 4'd4; in_valid = 1'b1;
    repeat (2) exp_q.push_back(mk(oh(4), 1'b0));
    for (int i = 0; i < 2; i++) begin
      tick();
      if (i == 0) bcd_in = 4'd8;
      else in_valid = 1'b0;
      e = exp_q.pop_front();
      n_checks++;
      if (p0 !== e.p0 || chk !== (|e.p0) || err !== e.err) begin
        n_fail++;
        $display("FAIL reset_mid_pre c%0d: p0=%b chk=%b err=%b, expected p0=%b chk=%b err=%b",
                 i, p0, chk, err, e.p0, |e.p0, e.err);
      end
    end
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_pend: in_ready=%b, expected 0", in_ready);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (p0 !== 10'd0 || chk !== 1'b0 || err !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_async: p0=%b chk=%b err=%b in_ready=%b, expected 0 0 0 1",
               p0, chk, err, in_ready);
    end
    tick();
    rst_n = 1'b1;
    repeat (5) exp_q.push_back(mk(10'd0, 1'b0));
    for (int i = 0; i < 5; i++) begin
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if (p0 !== e.p0 || chk !== (|e.p0) || err !== e.err) begin
        n_fail++;
        $display("FAIL reset_mid_post c%0d: p0=%b chk=%b err=%b, expected p0=%b chk=%b err=%b",
                 i, p0, chk, err, e.p0, |e.p0, e.err);
      end
    end
  endtask

  task automatic test_back_to_back_hold1();
    exp_t e;
    int   d;
    logic acc;
    logic rdy_low;
    d = 0; rdy_low = 1'b0;
    for (int k = 0; k < 10; k++) exp1_q.push_back(mk(oh(k), 1'b0));
    exp1_q.push_back(mk(10'd0, 1'b0));
    bcd1 = 4'd0; vld1 = 1'b1;
    for (int i = 0; i < 11; i++) begin
      if (rdy1 !== 1'b1) rdy_low = 1'b1;
      acc = vld1 && rdy1;
      tick();
      if (acc) begin
        d++;
        if (d == 10) vld1 = 1'b0;
        else bcd1 = 4'(d);
      end
      e = exp1_q.pop_front();
      n_checks++;
      if (p01 !== e.p0 || chk1 !== (|e.p0) || err1 !== e.err) begin
        n_fail++;
        $display("FAIL hold1 c%0d: p0=%b chk=%b err=%b, expected p0=%b chk=%b err=%b",
                 i, p01, chk1, err1, e.p0, |e.p0, e.err);
      end
    end
    n_checks++;
    if (rdy_low !== 1'b0 || d != 10) begin
      n_fail++;
      $display("FAIL hold1_ready: ready_dropped=%b accepted=%0d, expected 0 10", rdy_low, d);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_digit();
    test_sweep();
    test_illegal();
    test_bypass();
    test_clear();
    test_clr_same_cycle();
    test_reset_mid();
    test_back_to_back_hold1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
